// File: rtl/ysyx_25040111_memarb.sv
// Two-port round-robin arbiter onto one beat-level memory bus.
// Grant is locked per burst; ok/rdata steered back to the owner.
module ysyx_25040111_memarb #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              s0_start,
  input  logic [ADDR_W-1:0] s0_addr,
  input  logic [7:0]        s0_len,
  input  logic              s0_wen,
  input  logic [DATA_W-1:0] s0_wdata,
  input  logic [3:0]        s0_wmask,
  output logic              s0_ok,
  output logic [DATA_W-1:0] s0_rdata,
  input  logic              s1_start,
  input  logic [ADDR_W-1:0] s1_addr,
  input  logic [7:0]        s1_len,
  input  logic              s1_wen,
  input  logic [DATA_W-1:0] s1_wdata,
  input  logic [3:0]        s1_wmask,
  output logic              s1_ok,
  output logic [DATA_W-1:0] s1_rdata,
  output logic              m_start,
  output logic [ADDR_W-1:0] m_addr,
  output logic [7:0]        m_len,
  output logic              m_wen,
  output logic [DATA_W-1:0] m_wdata,
  output logic [3:0]        m_wmask,
  input  logic              m_ok,
  input  logic [DATA_W-1:0] m_rdata
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY0 = 2'd1,
    BUSY1 = 2'd2
  } state_e;

  state_e     state_q, state_d;
  logic       pend0_q, pend0_d;
  logic       pend1_q, pend1_d;
  logic       last_q, last_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] max_q, max_d;
  logic       mstart_q, mstart_d;

  logic req0, req1, any_req, win1;
  logic idle, busy0, busy1;
  logic own0, own1;

  assign idle  = (state_q == IDLE);
  assign busy0 = (state_q == BUSY0);
  assign busy1 = (state_q == BUSY1);

  // A start seen in IDLE competes in the same cycle.
  assign req0    = pend0_q | s0_start;
  assign req1    = pend1_q | s1_start;
  assign any_req = req0 | req1;
  assign win1    = req1 & (~req0 | ~last_q);

  assign own0 = busy0 | (idle & any_req & ~win1);
  assign own1 = busy1 | (idle & win1);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      pend0_q  <= 1'b0;
      pend1_q  <= 1'b0;
      last_q   <= 1'b1;
      cnt_q    <= 8'd0;
      max_q    <= 8'd0;
      mstart_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pend0_q  <= pend0_d;
      pend1_q  <= pend1_d;
      last_q   <= last_d;
      cnt_q    <= cnt_d;
      max_q    <= max_d;
      mstart_q <= mstart_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    cnt_d    = cnt_q;
    max_d    = max_q;
    mstart_d = 1'b0;
    pend0_d  = pend0_q | (s0_start & ~busy0);
    pend1_d  = pend1_q | (s1_start & ~busy1);
    case (state_q)
      IDLE: begin
        if (any_req) begin
          mstart_d = 1'b1;
          cnt_d    = 8'd0;
          last_d   = win1;
          if (win1) begin
            state_d = BUSY1;
            max_d   = s1_len;
            pend1_d = 1'b0;
          end else begin
            state_d = BUSY0;
            max_d   = s0_len;
            pend0_d = 1'b0;
          end
        end
      end
      BUSY0, BUSY1: begin
        mstart_d = busy0 ? s0_start : s1_start;
        if (m_ok) begin
          if (cnt_q == max_q) begin
            state_d = IDLE;
            cnt_d   = 8'd0;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    m_addr  = '0;
    m_len   = '0;
    m_wen   = 1'b0;
    m_wdata = '0;
    m_wmask = '0;
    unique case (1'b1)
      own0: begin
        m_addr  = s0_addr;
        m_len   = s0_len;
        m_wen   = s0_wen;
        m_wdata = s0_wdata;
        m_wmask = s0_wmask;
      end
      own1: begin
        m_addr  = s1_addr;
        m_len   = s1_len;
        m_wen   = s1_wen;
        m_wdata = s1_wdata;
        m_wmask = s1_wmask;
      end
      default: ;
    endcase
  end

  assign m_start  = mstart_q;
  assign s0_ok    = m_ok & busy0;
  assign s1_ok    = m_ok & busy1;
  assign s0_rdata = busy0 ? m_rdata : '0;
  assign s1_rdata = busy1 ? m_rdata : '0;

endmodule

// File: tb/tb_ysyx_25040111_memarb.sv
// Directed bench for the two-port round-robin memory arbiter.
// Inputs change 1ns after the rising edge; checks 1ns later.
module tb_ysyx_25040111_memarb;

  logic        clock;
  logic        reset;
  logic        s0_start, s1_start;
  logic [31:0] s0_addr, s1_addr;
  logic [7:0]  s0_len, s1_len;
  logic        s0_wen, s1_wen;
  logic [31:0] s0_wdata, s1_wdata;
  logic [3:0]  s0_wmask, s1_wmask;
  logic        s0_ok, s1_ok;
  logic [31:0] s0_rdata, s1_rdata;
  logic        m_start;
  logic [31:0] m_addr;
  logic [7:0]  m_len;
  logic        m_wen;
  logic [31:0] m_wdata;
  logic [3:0]  m_wmask;
  logic        m_ok;
  logic [31:0] m_rdata;

  int nvec = 0;
  int nerr = 0;

  ysyx_25040111_memarb #(.ADDR_W(32), .DATA_W(32)) dut (
    .clock(clock), .reset(reset),
    .s0_start(s0_start), .s0_addr(s0_addr),
    .s0_len(s0_len), .s0_wen(s0_wen),
    .s0_wdata(s0_wdata), .s0_wmask(s0_wmask),
    .s0_ok(s0_ok), .s0_rdata(s0_rdata),
    .s1_start(s1_start), .s1_addr(s1_addr),
    .s1_len(s1_len), .s1_wen(s1_wen),
    .s1_wdata(s1_wdata), .s1_wmask(s1_wmask),
    .s1_ok(s1_ok), .s1_rdata(s1_rdata),
    .m_start(m_start), .m_addr(m_addr),
    .m_len(m_len), .m_wen(m_wen),
    .m_wdata(m_wdata), .m_wmask(m_wmask),
    .m_ok(m_ok), .m_rdata(m_rdata)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic nxt();
    @(posedge clock);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h",
             tag, obs, exp);
    end
  endtask

  // One beat on port p: start, expect m_start next cycle, then ok.
  task automatic rd_beat(input int p,
                         input logic [31:0] a,
                         input logic [31:0] d,
                         input logic [7:0] l);
    nxt();
    if (p == 0) begin
      s0_start = 1'b1; s0_addr = a;
    end else begin
      s1_start = 1'b1; s1_addr = a;
    end
    settle();
    chk("beat_pre_mstart", m_start, 0);
    nxt();
    s0_start = 1'b0;
    s1_start = 1'b0;
    settle();
    chk("beat_mstart", m_start, 1);
    chk("beat_maddr", m_addr, a);
    chk("beat_mlen", m_len, l);
    nxt();
    m_ok = 1'b1;
    m_rdata = d;
    settle();
    chk("beat_mstart_off", m_start, 0);
    chk("beat_ok", (p == 0) ? s0_ok : s1_ok, 1);
    chk("beat_rdata", (p == 0) ? s0_rdata : s1_rdata, d);
    chk("beat_other_ok", (p == 0) ? s1_ok : s0_ok, 0);
    nxt();
    m_ok = 1'b0;
    m_rdata = '0;
  endtask

  initial begin
    logic [31:0] d4 [4];
    int w;
    d4[0] = 32'h11; d4[1] = 32'h22;
    d4[2] = 32'h33; d4[3] = 32'h44;
    reset = 1'b0;
    s0_start = 0; s1_start = 0;
    s0_addr = 0; s1_addr = 0;
    s0_len = 0; s1_len = 0;
    s0_wen = 0; s1_wen = 0;
    s0_wdata = 0; s1_wdata = 0;
    s0_wmask = 0; s1_wmask = 0;
    m_ok = 1'b1;
    m_rdata = 32'hAA;

    // reset state, stray ok gated
    repeat (2) @(posedge clock);
    settle();
    chk("rst_mstart", m_start, 0);
    chk("rst_s0ok", s0_ok, 0);
    chk("rst_s1ok", s1_ok, 0);
    chk("rst_s0rdata", s0_rdata, 0);
    chk("rst_maddr", m_addr, 0);
    chk("rst_mwen", m_wen, 0);
    nxt();
    reset = 1'b1;
    m_ok = 1'b0;
    m_rdata = '0;

    // single port-0 read burst of 4 beats
    s0_len = 8'd3;
    for (int b = 0; b < 4; b++)
      rd_beat(0, 32'h1000 + 32'(b * 4), d4[b], 8'd3);
    m_ok = 1'b1;
    m_rdata = 32'h5A;
    settle();
    chk("t1_idle_s0ok", s0_ok, 0);
    chk("t1_idle_s1ok", s1_ok, 0);
    chk("t1_idle_mstart", m_start, 0);
    nxt();
    m_ok = 1'b0;

    // tie straight out of reset: port 0 first
    reset = 1'b0;
    nxt();
    reset = 1'b1;
    nxt();
    s0_len = 0; s1_len = 0;
    s0_addr = 32'hA000; s1_addr = 32'hB000;
    s0_start = 1; s1_start = 1;
    settle();
    chk("t2_tie_addr", m_addr, 32'hA000);
    nxt();
    s0_start = 0; s1_start = 0;
    settle();
    chk("t2_mstart0", m_start, 1);
    chk("t2_addr0", m_addr, 32'hA000);
    nxt();
    m_ok = 1; m_rdata = 32'hC0;
    settle();
    chk("t2_s0ok", s0_ok, 1);
    chk("t2_s1ok_no", s1_ok, 0);
    nxt();
    m_ok = 0; m_rdata = 0;
    settle();
    chk("t2_gap_mstart", m_start, 0);
    chk("t2_idle_addr1", m_addr, 32'hB000);
    nxt();
    settle();
    chk("t2_mstart1", m_start, 1);
    chk("t2_addr1", m_addr, 32'hB000);
    nxt();
    m_ok = 1; m_rdata = 32'hC1;
    settle();
    chk("t2_s1ok", s1_ok, 1);
    chk("t2_s1rdata", s1_rdata, 32'hC1);
    chk("t2_s0ok_no", s0_ok, 0);
    nxt();
    m_ok = 0; m_rdata = 0;

    // 8 back-to-back ties must alternate 0,1,0,1...
    for (int i = 0; i < 8; i++) begin
      w = i % 2;
      nxt();
      m_ok = 0;
      s0_start = 1; s1_start = 1;
      settle();
      chk("rr_pre_mstart", m_start, 0);
      chk("rr_idle_addr", m_addr,
          (w == 0) ? 32'hA000 : 32'hB000);
      nxt();
      s0_start = 0; s1_start = 0;
      settle();
      chk("rr_mstart", m_start, 1);
      chk("rr_addr", m_addr,
          (w == 0) ? 32'hA000 : 32'hB000);
      nxt();
      m_ok = 1; m_rdata = 32'(i);
      settle();
      chk("rr_ok_win", (w == 0) ? s0_ok : s1_ok, 1);
      chk("rr_ok_lose", (w == 0) ? s1_ok : s0_ok, 0);
    end
    nxt();
    m_ok = 0;
    settle();
    chk("rr_drain_addr", m_addr, 32'hA000);
    chk("rr_drain_pre", m_start, 0);
    nxt();
    settle();
    chk("rr_drain_mstart", m_start, 1);
    nxt();
    m_ok = 1;
    settle();
    chk("rr_drain_ok", s0_ok, 1);
    nxt();
    m_ok = 0;

    // port-1 write queued behind a 4-beat port-0 burst
    s0_len = 8'd3;
    s1_len = 8'd0;
    rd_beat(0, 32'h3000, 32'hE0, 8'd3);
    nxt();
    s1_start = 1; s1_wen = 1;
    s1_addr = 32'h2000;
    s1_wdata = 32'hDEADBEEF;
    s1_wmask = 4'hF;
    settle();
    chk("t4_mid_mstart", m_start, 0);
    chk("t4_mid_addr", m_addr, 32'h3000);
    chk("t4_mid_wen", m_wen, 0);
    nxt();
    s1_start = 0;
    for (int b = 1; b < 4; b++)
      rd_beat(0, 32'h3000 + 32'(b * 4),
              32'hE0 + 32'(b), 8'd3);
    settle();
    chk("t4_idle_addr", m_addr, 32'h2000);
    chk("t4_idle_wen", m_wen, 1);
    chk("t4_idle_mstart", m_start, 0);
    nxt();
    settle();
    chk("t4_mstart", m_start, 1);
    chk("t4_wdata", m_wdata, 32'hDEADBEEF);
    chk("t4_wmask", m_wmask, 4'hF);
    nxt();
    m_ok = 1;
    settle();
    chk("t4_s1ok", s1_ok, 1);
    chk("t4_s0ok_no", s0_ok, 0);
    nxt();
    m_ok = 0;
    settle();
    chk("t4_s1ok_once", s1_ok, 0);
    chk("t4_mstart_off", m_start, 0);
    s1_wen = 0;

    // reset during beat 2 of a port-0 burst
    rd_beat(0, 32'h4000, 32'h40, 8'd3);
    nxt();
    s0_start = 1;
    s0_addr = 32'h4004;
    nxt();
    s0_start = 0;
    settle();
    chk("t5_mstart", m_start, 1);
    reset = 1'b0;
    settle();
    chk("t5_rst_mstart", m_start, 0);
    chk("t5_rst_addr", m_addr, 0);
    nxt();
    reset = 1'b1;
    m_ok = 1;
    m_rdata = 32'h55;
    settle();
    chk("t5_s0ok", s0_ok, 0);
    chk("t5_s1ok", s1_ok, 0);
    chk("t5_s0rdata", s0_rdata, 0);
    chk("t5_mstart2", m_start, 0);
    nxt();
    m_ok = 0;
    m_rdata = 0;
    settle();
    chk("t5_no_regrant", m_start, 0);

    // stray ok in IDLE, then a 1-beat burst must still end on 1 ok
    nxt();
    m_ok = 1;
    m_rdata = 32'h77;
    settle();
    chk("t6_s0ok", s0_ok, 0);
    chk("t6_s1ok", s1_ok, 0);
    chk("t6_s0rdata", s0_rdata, 0);
    nxt();
    m_ok = 0;
    s0_len = 0;
    rd_beat(0, 32'h5000, 32'h99, 8'd0);
    m_ok = 1;
    settle();
    chk("t6_burst_end", s0_ok, 0);
    nxt();
    m_ok = 0;

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nerr);
    $finish;
  end

endmodule

// File: doc/ysyx_25040111_memarb.md
# ysyx_25040111_memarb

Two-port round-robin arbiter that shares one downstream beat-level memory bus between the instruction-cache refill port (port 0) and the load/store unit (port 1). Each requester runs the same per-beat start/ok protocol the cache refill path uses: one `start` pulse per beat, one `ok` pulse per returned beat, and `len+1` beats per burst. The arbiter locks the grant for the whole burst, muxes request fields down and steers `ok`/`rdata` back. It sits between the cache/LSU and the system bus bridge.

## Interface
- `ADDR_W`, 32: address width.
- `DATA_W`, 32: data width.
- `clock`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low reset; `0` forces the reset state immediately.
- `s0_start`, `s1_start`  in  1 each  one-cycle beat request pulse.
- `s0_addr`, `s1_addr`  in  ADDR_W  beat address; held stable by the requester from `start` until its `ok`.
- `s0_len`, `s1_len`  in  8  burst length minus 1; stable for the whole burst.
- `s0_wen`, `s1_wen`  in  1  1 means a write beat.
- `s0_wdata`, `s1_wdata`  in  DATA_W  write data.
- `s0_wmask`, `s1_wmask`  in  4  byte strobes.
- `s0_ok`, `s1_ok`  out  1 each  beat-complete pulse.
- `s0_rdata`, `s1_rdata`  out  DATA_W  read data; valid when the matching `ok` is high.
- `m_start`  out  1  downstream beat request pulse (registered).
- `m_addr`  out  ADDR_W  downstream address (muxed from the granted port).
- `m_len`  out  8  downstream length (muxed from the granted port).
- `m_wen`  out  1  downstream write enable (muxed from the granted port).
- `m_wdata`  out  DATA_W  downstream write data (muxed from the granted port).
- `m_wmask`  out  4  downstream byte strobes (muxed from the granted port).
- `m_ok`  in  1  downstream beat-complete pulse.
- `m_rdata`  in  DATA_W  downstream read data.

## Operation
- States:
  - IDLE: no grant.
  - BUSY0: burst owned by port 0.
  - BUSY1: burst owned by port 1.
- Pending flags:
  - `pend0` and `pend1` set on `sN_start` whenever port N is not the owner in a BUSY state.
  - A flag clears when that port's first beat is issued.
  - A second `start` on a port whose flag is already set is a no-op.
- Round-robin:
  - Register `last` holds the most recently granted port.
  - If only one port is pending, that port wins.
  - If both are pending, the port that is not `last` wins.
  - `last` resets to 1, so port 0 wins the first tie.
- IDLE with any pending port:
  - Go to BUSYw, where w is the winner.
  - Pulse `m_start`.
  - Latch `beat_max <= sw_len` and set `beat_cnt <= 0`.
  - Set `last <= w` and clear `pendw`.
- BUSYw, issuing further beats:
  - `sw_start` causes an `m_start` pulse on the next cycle.
  - A start from the other port only sets its pending flag.
- BUSYw, returning beats:
  - `sw_ok = m_ok` and `sw_rdata = m_rdata`, combinationally in the same cycle.
  - On `m_ok`, `beat_cnt` increments.
- Burst end: `m_ok` with `beat_cnt == beat_max` ends the burst and returns to IDLE. The next grant is decided in IDLE, so there is one idle cycle between bursts.
- Muxing:
  - In BUSYw, the `m_addr/len/wen/wdata/wmask` fields come from port w.
  - In IDLE, they come from the winner, so they are valid alongside `m_start`.
  - With no request in IDLE, all of those fields are 0.
- Ok gating:
  - `sN_ok` is 0 unless in BUSYN.
  - A stray `m_ok` in IDLE is dropped.
  - `sN_rdata` is 0 when not granted.
- Widths: `beat_cnt` and `beat_max` are 8 bits, giving at most 256 beats per burst. The counter never wraps within a burst.

## Timing
- Reset values:
  - State IDLE.
  - `pend0 = pend1 = 0`, `last = 1`, `beat_cnt = 0`, `beat_max = 0`.
  - Outputs `m_start = 0`, `s0_ok = s1_ok = 0`, all data outputs 0.
- Grant latency: `sN_start` in cycle t with the arbiter in IDLE gives `m_start` high in cycle t+1.
- Burst-internal start: `sw_start` in cycle t gives `m_start` in cycle t+1.
- Ok and rdata have zero-cycle latency from `m_ok`/`m_rdata`.
- `m_start` is never high for more than one cycle per beat, and never high while a beat is outstanding.
- Simultaneous events:
  - `m_ok` on the last beat together with the other port's `start`: the flag is set, and the grant follows 2 cycles later via IDLE.
  - `s0_start` and `s1_start` in the same IDLE cycle: the round-robin winner goes first, and the loser stays pending.
- Reset mid-burst:
  - All state returns to IDLE immediately and pending flags are lost.
  - Any later `m_ok` for the aborted beat is dropped.

## Test plan
- Single port-0 read, `s0_len = 3`, one `s0_start` per beat after each `ok`, `m_rdata` = 0x11, 0x22, 0x33, 0x44 -> 4 `m_start` pulses, `s0_rdata` values in that order, `s1_ok` always 0, IDLE after the 4th `m_ok`.
- Both ports start in the same cycle straight out of reset -> port 0 granted first (`m_addr = s0_addr`). After its burst ends, port 1 is granted with `m_start` exactly 2 cycles after the last `m_ok`.
- Second tie after a port-0 burst -> port 1 wins. Alternate for 8 bursts and check strict alternation of the grant.
- Port 1 write beat (`s1_wen = 1`, `wdata = 0xDEADBEEF`, `wmask = 0xF`) issued while port 0 is mid-burst (`len = 3`) -> port 1 fields appear on `m_*` only after port 0's 4th `ok`, and `s1_ok` arrives once.
- Drive `reset = 0` during beat 2 of a port-0 burst, then release and inject `m_ok` -> all outputs are 0 and no `s0_ok` or `s1_ok` is produced.
- Raise `m_ok` while in IDLE with no pending request -> no `sN_ok`, state stays IDLE, and `beat_cnt` stays 0.
